id_ex_stage: RTL

ID/EX pipeline stage sitting directly downstream of `RegFile`. It takes the decoded source/destination selects and the two register-file read values, bypasses a same-cycle writeback, and detects load-use hazards, inserting one bubble. It also honours a downstream stall and a branch flush, and registers the operand bundle for the execute stage. A saturating counter records inserted bubbles for performance monitoring.

---
 rtl/riscv_pipe_pkg.sv | 13 +
 rtl/id_ex_stage_if.sv | 44 ++++
 rtl/hazard_detect.sv | 39 +++
 rtl/id_ex_stage.sv | 80 ++++++++
 4 files changed

// File: rtl/riscv_pipe_pkg.sv
// riscv_pipe_pkg: shared widths, operand-select encoding and EX control bundle
package riscv_pipe_pkg;
  localparam int DATA_WIDTH_D = 32;
  localparam int ADDR_WIDTH_D = 5;
  localparam int CNT_WIDTH_D = 16;
  localparam logic [4:0] ZERO_REG = 5'd0;
  typedef enum logic [1:0] {OP_ZERO, OP_WB, OP_RF} op_sel_t;
  typedef struct packed {
    logic valid;
    logic rd_wen;
    logic is_load;
  } ex_ctrl_t;
endpackage

// File: rtl/id_ex_stage_if.sv
// id_ex_stage_if: decode, regfile, writeback and execute-bundle signals of the ID/EX stage
interface id_ex_stage_if #(
  parameter int DATA_WIDTH = riscv_pipe_pkg::DATA_WIDTH_D,
  parameter int ADDR_WIDTH = riscv_pipe_pkg::ADDR_WIDTH_D,
  parameter int CNT_WIDTH = riscv_pipe_pkg::CNT_WIDTH_D
);
  logic                  ID_VALID;
  logic [ADDR_WIDTH-1:0] ID_RS1_SEL;
  logic [ADDR_WIDTH-1:0] ID_RS2_SEL;
  logic                  ID_USES_RS1;
  logic                  ID_USES_RS2;
  logic [ADDR_WIDTH-1:0] ID_RD_SEL;
  logic                  ID_RD_WEN;
  logic                  ID_IS_LOAD;
  logic [DATA_WIDTH-1:0] SRC1_DOUT;
  logic [DATA_WIDTH-1:0] SRC2_DOUT;
  logic                  WB_WEN;
  logic [ADDR_WIDTH-1:0] WB_RD_SEL;
  logic [DATA_WIDTH-1:0] WB_DATA;
  logic                  EX_STALL;
  logic                  FLUSH;
  logic                  ID_READY;
  logic                  EX_VALID;
  logic [DATA_WIDTH-1:0] EX_RS1_VAL;
  logic [DATA_WIDTH-1:0] EX_RS2_VAL;
  logic [ADDR_WIDTH-1:0] EX_RS1_SEL;
  logic [ADDR_WIDTH-1:0] EX_RS2_SEL;
  logic [ADDR_WIDTH-1:0] EX_RD_SEL;
  logic                  EX_RD_WEN;
  logic                  EX_IS_LOAD;
  logic [CNT_WIDTH-1:0]  BUBBLE_CNT;
  modport master (
    output ID_VALID, ID_RS1_SEL, ID_RS2_SEL, ID_USES_RS1, ID_USES_RS2, ID_RD_SEL, ID_RD_WEN,
           ID_IS_LOAD, SRC1_DOUT, SRC2_DOUT, WB_WEN, WB_RD_SEL, WB_DATA, EX_STALL, FLUSH,
    input  ID_READY, EX_VALID, EX_RS1_VAL, EX_RS2_VAL, EX_RS1_SEL, EX_RS2_SEL, EX_RD_SEL,
           EX_RD_WEN, EX_IS_LOAD, BUBBLE_CNT
  );
  modport slave (
    input  ID_VALID, ID_RS1_SEL, ID_RS2_SEL, ID_USES_RS1, ID_USES_RS2, ID_RD_SEL, ID_RD_WEN,
           ID_IS_LOAD, SRC1_DOUT, SRC2_DOUT, WB_WEN, WB_RD_SEL, WB_DATA, EX_STALL, FLUSH,
    output ID_READY, EX_VALID, EX_RS1_VAL, EX_RS2_VAL, EX_RS1_SEL, EX_RS2_SEL, EX_RD_SEL,
           EX_RD_WEN, EX_IS_LOAD, BUBBLE_CNT
  );
endinterface

// File: rtl/hazard_detect.sv
// hazard_detect: load-use hazard, ID operand bypass selects and EX operand refresh flags
module hazard_detect
  import riscv_pipe_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_D
) (
  input  logic                  id_valid,
  input  logic [ADDR_WIDTH-1:0] id_rs1_sel,
  input  logic [ADDR_WIDTH-1:0] id_rs2_sel,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic                  ex_valid,
  input  logic                  ex_is_load,
  input  logic                  ex_rd_wen,
  input  logic [ADDR_WIDTH-1:0] ex_rd_sel,
  input  logic [ADDR_WIDTH-1:0] ex_rs1_sel,
  input  logic [ADDR_WIDTH-1:0] ex_rs2_sel,
  input  logic                  wb_wen,
  input  logic [ADDR_WIDTH-1:0] wb_rd_sel,
  output logic                  hazard,
  output op_sel_t               op1_sel,
  output op_sel_t               op2_sel,
  output logic                  refresh1,
  output logic                  refresh2
);
  localparam logic [ADDR_WIDTH-1:0] ZERO = ADDR_WIDTH'(ZERO_REG);
  logic wb_live;
  logic ex_load_live;
  always_comb begin
    wb_live = wb_wen && wb_rd_sel != ZERO;
    ex_load_live = ex_valid && ex_is_load && ex_rd_wen && ex_rd_sel != ZERO;
    op1_sel = id_rs1_sel == ZERO ? OP_ZERO : (wb_wen && wb_rd_sel == id_rs1_sel) ? OP_WB : OP_RF;
    op2_sel = id_rs2_sel == ZERO ? OP_ZERO : (wb_wen && wb_rd_sel == id_rs2_sel) ? OP_WB : OP_RF;
    refresh1 = wb_live && wb_rd_sel == ex_rs1_sel;
    refresh2 = wb_live && wb_rd_sel == ex_rs2_sel;
    hazard = id_valid && ex_load_live &&
             ((id_uses_rs1 && id_rs1_sel == ex_rd_sel) || (id_uses_rs2 && id_rs2_sel == ex_rd_sel));
  end
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with WB bypass, load-use bubbling, stall/flush and bubble counter
module id_ex_stage
  import riscv_pipe_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_D,
  parameter int ADDR_WIDTH = ADDR_WIDTH_D,
  parameter int CNT_WIDTH = CNT_WIDTH_D
) (
  input logic         CLK,
  input logic         RESET,
  id_ex_stage_if.slave bus
);
  ex_ctrl_t              ctrl;
  logic [DATA_WIDTH-1:0] rs1_val, rs2_val, op1, op2;
  logic [ADDR_WIDTH-1:0] rs1_sel, rs2_sel, rd_sel;
  logic [CNT_WIDTH-1:0]  cnt;
  logic                  hazard, refresh1, refresh2;
  op_sel_t               op1_sel, op2_sel;
  hazard_detect #(.ADDR_WIDTH(ADDR_WIDTH)) u_hazard (
    .id_valid    (bus.ID_VALID),
    .id_rs1_sel  (bus.ID_RS1_SEL),
    .id_rs2_sel  (bus.ID_RS2_SEL),
    .id_uses_rs1 (bus.ID_USES_RS1),
    .id_uses_rs2 (bus.ID_USES_RS2),
    .ex_valid    (ctrl.valid),
    .ex_is_load  (ctrl.is_load),
    .ex_rd_wen   (ctrl.rd_wen),
    .ex_rd_sel   (rd_sel),
    .ex_rs1_sel  (rs1_sel),
    .ex_rs2_sel  (rs2_sel),
    .wb_wen      (bus.WB_WEN),
    .wb_rd_sel   (bus.WB_RD_SEL),
    .hazard      (hazard),
    .op1_sel     (op1_sel),
    .op2_sel     (op2_sel),
    .refresh1    (refresh1),
    .refresh2    (refresh2)
  );
  always_comb begin
    op1 = op1_sel == OP_ZERO ? '0 : op1_sel == OP_WB ? bus.WB_DATA : bus.SRC1_DOUT;
    op2 = op2_sel == OP_ZERO ? '0 : op2_sel == OP_WB ? bus.WB_DATA : bus.SRC2_DOUT;
  end
  // flush beats stall, stall beats the hazard bubble
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      ctrl <= '0;
      rs1_val <= '0;
      rs2_val <= '0;
      rs1_sel <= '0;
      rs2_sel <= '0;
      rd_sel <= '0;
      cnt <= '0;
    end else if (bus.FLUSH) begin
      ctrl.valid <= 1'b0;
    end else if (bus.EX_STALL) begin
      if (refresh1) rs1_val <= bus.WB_DATA;
      if (refresh2) rs2_val <= bus.WB_DATA;
    end else if (hazard) begin
      ctrl.valid <= 1'b0;
      cnt <= cnt + CNT_WIDTH'(cnt != '1);
    end else begin
      ctrl <= '{valid: bus.ID_VALID, rd_wen: bus.ID_RD_WEN, is_load: bus.ID_IS_LOAD};
      rs1_val <= op1;
      rs2_val <= op2;
      rs1_sel <= bus.ID_RS1_SEL;
      rs2_sel <= bus.ID_RS2_SEL;
      rd_sel <= bus.ID_RD_SEL;
    end
  end
  assign bus.ID_READY = bus.FLUSH || (!bus.EX_STALL && !hazard);
  assign bus.EX_VALID = ctrl.valid;
  assign bus.EX_RD_WEN = ctrl.rd_wen;
  assign bus.EX_IS_LOAD = ctrl.is_load;
  assign bus.EX_RS1_VAL = rs1_val;
  assign bus.EX_RS2_VAL = rs2_val;
  assign bus.EX_RS1_SEL = rs1_sel;
  assign bus.EX_RS2_SEL = rs2_sel;
  assign bus.EX_RD_SEL = rd_sel;
  assign bus.BUBBLE_CNT = cnt;
endmodule
